// File: rtl/uart_rx_stream_if.sv
// Received-word stream: word plus per-word error flags on a valid/ready handshake.
interface uart_rx_stream_if #(
    parameter int unsigned P_DATA_BITS = 8
);
    logic [P_DATA_BITS-1:0] o_data;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_parity_err;
    logic                   o_frame_err;

    modport master (
        output o_data,
        output o_valid,
        input  i_ready,
        output o_parity_err,
        output o_frame_err
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output i_ready,
        input  o_parity_err,
        input  o_frame_err
    );
endinterface

// File: rtl/uart_rx_stream.sv
// UART receiver with mid-bit sampling and false-start rejection; emits each received
// word with parity/framing flags on a single-entry valid/ready output register.
module uart_rx_stream #(
    parameter int unsigned P_CLKS_PER_BIT = 8,
    parameter int unsigned P_DATA_BITS    = 8,
    parameter int unsigned P_PARITY       = 0,
    parameter int unsigned P_STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rx,
    uart_rx_stream_if.master o_stream,
    output logic             o_overrun,
    output logic             o_busy
);
    localparam int unsigned LP_TW = (P_CLKS_PER_BIT > 1) ? $clog2(P_CLKS_PER_BIT) : 1;
    localparam int unsigned LP_BW = $clog2(P_DATA_BITS + 1);
    localparam logic [LP_TW-1:0] LP_FULL      = LP_TW'(P_CLKS_PER_BIT - 1);
    localparam logic [LP_TW-1:0] LP_HALF      = LP_TW'(P_CLKS_PER_BIT / 2 - 1);
    localparam logic [LP_BW-1:0] LP_LAST_DATA = LP_BW'(P_DATA_BITS - 1);
    localparam logic [LP_BW-1:0] LP_LAST_STOP = LP_BW'(P_STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_sync;
    logic [LP_TW-1:0]       r_timer;
    logic [LP_BW-1:0]       r_bit_cnt;
    logic [P_DATA_BITS-1:0] r_shift;
    logic                   r_par_err;
    logic                   r_frm_err;
    logic [P_DATA_BITS-1:0] r_data;
    logic                   r_valid;
    logic                   r_data_perr;
    logic                   r_data_ferr;
    logic                   r_overrun;
    logic                   r_busy;

    logic w_rx;
    logic w_sample;
    logic w_par_bad;
    logic w_frm_err_final;

    assign w_rx            = r_sync[1];
    assign w_sample        = (r_timer == '0);
    assign w_par_bad       = (P_PARITY == 1) ? ~(^r_shift ^ w_rx) : (^r_shift ^ w_rx);
    // Framing error including the stop sample being taken this cycle
    assign w_frm_err_final = r_frm_err | ~w_rx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_data_perr <= 1'b0;
            r_data_ferr <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_overrun <= 1'b0;
            if (r_valid && o_stream.i_ready) begin
                r_valid <= 1'b0;
            end
            if (r_state != S_IDLE && r_state != S_BREAK) begin
                r_timer <= w_sample ? LP_FULL : r_timer - LP_TW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rx) begin
                        r_state <= S_START;
                        r_timer <= LP_HALF;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_sample) begin
                        if (w_rx) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                            r_par_err <= 1'b0;
                            r_frm_err <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift <= {w_rx, r_shift[P_DATA_BITS-1:1]};
                        if (r_bit_cnt == LP_LAST_DATA) begin
                            r_bit_cnt <= '0;
                            r_state   <= (P_PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + LP_BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_sample) begin
                        r_par_err <= w_par_bad;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_sample) begin
                        r_frm_err <= w_frm_err_final;
                        if (r_bit_cnt == LP_LAST_STOP) begin
                            // Held word is kept; a frame arriving while it is stalled is dropped
                            if (!r_valid || o_stream.i_ready) begin
                                r_data      <= r_shift;
                                r_valid     <= 1'b1;
                                r_data_perr <= r_par_err;
                                r_data_ferr <= w_frm_err_final;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            if (w_frm_err_final && (r_shift == '0)) begin
                                r_state <= S_BREAK;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + LP_BW'(1);
                        end
                    end
                end
                S_BREAK: begin
                    if (w_rx) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_stream.o_data       = r_data;
    assign o_stream.o_valid      = r_valid;
    assign o_stream.o_parity_err = r_data_perr;
    assign o_stream.o_frame_err  = r_data_ferr;
    assign o_overrun             = r_overrun;
    assign o_busy                = r_busy;
endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream: three configurations driven by directed and random frames,
// checked every cycle against a frame-level model of the output register.
module tb_uart_rx_stream;
    localparam int C0 = 8, N0 = 8, PA0 = 0, S0 = 1;
    localparam int C1 = 6, N1 = 8, PA1 = 2, S1 = 2;
    localparam int C2 = 4, N2 = 5, PA2 = 1, S2 = 1;

    typedef struct {
        int         dut;
        int         done;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] rx;
    logic [2:0] rdy;
    logic [2:0] dv, dpe, dfe, dovr, dbusy;
    logic [8:0] ddat [3];

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t pend [$];
    exp_t be;

    int         ready_mode [3];
    logic       m_full [3];
    logic [8:0] m_data [3];
    logic       m_pe [3];
    logic       m_fe [3];
    logic       m_found, m_eovr;
    exp_t       m_w;
    logic [2:0] dv_q = 3'b000;
    int         rise_cyc [3];
    int         last_start [3];
    int         n_words [3];
    int         n_ovr [3];
    logic [8:0] last_data [3];
    logic       last_pe [3];
    logic       last_fe [3];
    int         w0, o0;

    uart_rx_stream_if #(.P_DATA_BITS(N0)) if0 ();
    uart_rx_stream_if #(.P_DATA_BITS(N1)) if1 ();
    uart_rx_stream_if #(.P_DATA_BITS(N2)) if2 ();

    uart_rx_stream #(.P_CLKS_PER_BIT(C0), .P_DATA_BITS(N0), .P_PARITY(PA0), .P_STOP_BITS(S0)) dut0 (
        .clk(clk), .rst(rst), .i_rx(rx[0]), .o_stream(if0), .o_overrun(dovr[0]), .o_busy(dbusy[0]));
    uart_rx_stream #(.P_CLKS_PER_BIT(C1), .P_DATA_BITS(N1), .P_PARITY(PA1), .P_STOP_BITS(S1)) dut1 (
        .clk(clk), .rst(rst), .i_rx(rx[1]), .o_stream(if1), .o_overrun(dovr[1]), .o_busy(dbusy[1]));
    uart_rx_stream #(.P_CLKS_PER_BIT(C2), .P_DATA_BITS(N2), .P_PARITY(PA2), .P_STOP_BITS(S2)) dut2 (
        .clk(clk), .rst(rst), .i_rx(rx[2]), .o_stream(if2), .o_overrun(dovr[2]), .o_busy(dbusy[2]));

    assign if0.i_ready = rdy[0];
    assign if1.i_ready = rdy[1];
    assign if2.i_ready = rdy[2];
    assign dv  = {if2.o_valid, if1.o_valid, if0.o_valid};
    assign dpe = {if2.o_parity_err, if1.o_parity_err, if0.o_parity_err};
    assign dfe = {if2.o_frame_err, if1.o_frame_err, if0.o_frame_err};
    assign ddat[0] = 9'(if0.o_data);
    assign ddat[1] = 9'(if1.o_data);
    assign ddat[2] = 9'(if2.o_data);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cpb(input int d);
        return (d == 0) ? C0 : (d == 1) ? C1 : C2;
    endfunction
    function automatic int nbits(input int d);
        return (d == 0) ? N0 : (d == 1) ? N1 : N2;
    endfunction
    function automatic int par(input int d);
        return (d == 0) ? PA0 : (d == 1) ? PA1 : PA2;
    endfunction
    function automatic int stp(input int d);
        return (d == 0) ? S0 : (d == 1) ? S1 : S2;
    endfunction

    // Edge count at which the word becomes visible, for a start bit driven when cyc == start:
    // two synchroniser edges, one edge to leave idle, half a bit, then one bit per remaining frame bit.
    function automatic int done_edge(input int d, input int start);
        int fb;
        fb = 1 + nbits(d) + ((par(d) != 0) ? 1 : 0) + stp(d);
        return start + 3 + cpb(d) / 2 + (fb - 1) * cpb(d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input int d, input logic [8:0] data, input logic bad_par,
                              input logic [1:0] stop_v, input int idle_bits);
        int         p;
        int         n;
        logic [8:0] word;
        logic       pb;
        exp_t       e;
        p    = cpb(d);
        n    = nbits(d);
        word = data & ((9'd1 << n) - 9'd1);
        pb   = ((par(d) == 1) ? ~(^word) : (^word)) ^ bad_par;
        @(negedge clk);
        e.dut  = d;
        e.done = done_edge(d, cyc);
        e.data = word;
        e.perr = (par(d) != 0) && bad_par;
        e.ferr = !stop_v[0] || ((stp(d) == 2) && !stop_v[1]);
        pend.push_back(e);
        last_start[d] = cyc;
        rx[d] = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rx[d] = word[i];
            repeat (p) @(negedge clk);
        end
        if (par(d) != 0) begin
            rx[d] = pb;
            repeat (p) @(negedge clk);
        end
        for (int s = 0; s < stp(d); s++) begin
            rx[d] = stop_v[s];
            repeat (p) @(negedge clk);
        end
        rx[d] = 1'b1;
        repeat (idle_bits * p) @(negedge clk);
    endtask

    task automatic random_frames(input int d, input int count);
        logic [8:0] data;
        logic       bp;
        logic [1:0] sv;
        int         idle;
        for (int k = 0; k < count; k++) begin
            data  = 9'($urandom_range(0, 511));
            bp    = (par(d) != 0) && ($urandom_range(0, 3) == 0);
            sv[0] = ($urandom_range(0, 7) != 0);
            sv[1] = ($urandom_range(0, 7) != 0);
            idle  = $urandom_range(0, 2);
            // A low stop bit needs idle line after it, else the next start is misaligned
            if (!(sv[0] && sv[1]) && idle == 0) idle = 1;
            send_frame(d, data, bp, sv, idle);
        end
    endtask

    // Frame-level model of the single-entry output register, compared every cycle
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            m_found = 1'b0;
            m_eovr  = 1'b0;
            if (rst) begin
                m_full[d] = 1'b0;
            end else begin
                for (int i = pend.size() - 1; i >= 0; i--) begin
                    if (pend[i].dut == d && pend[i].done == cyc) begin
                        m_w     = pend[i];
                        m_found = 1'b1;
                        pend.delete(i);
                    end
                end
                if (m_found) begin
                    if (!m_full[d] || rdy[d]) begin
                        m_full[d] = 1'b1;
                        m_data[d] = m_w.data;
                        m_pe[d]   = m_w.perr;
                        m_fe[d]   = m_w.ferr;
                    end else begin
                        m_eovr = 1'b1;
                    end
                end else if (m_full[d] && rdy[d]) begin
                    m_full[d] = 1'b0;
                end
            end
            check($sformatf("d%0d valid", d), 32'(dv[d]), 32'(m_full[d]));
            check($sformatf("d%0d overrun", d), 32'(dovr[d]), 32'(m_eovr));
            if (m_full[d]) begin
                check($sformatf("d%0d data", d), 32'(ddat[d]), 32'(m_data[d]));
                check($sformatf("d%0d parity_err", d), 32'(dpe[d]), 32'(m_pe[d]));
                check($sformatf("d%0d frame_err", d), 32'(dfe[d]), 32'(m_fe[d]));
            end
            if (dv[d] && !dv_q[d]) rise_cyc[d] = cyc;
            dv_q[d] = dv[d];
            if (dovr[d]) n_ovr[d]++;
            case (ready_mode[d])
                0:       rdy[d] = 1'b0;
                1:       rdy[d] = 1'b1;
                default: rdy[d] = ($urandom_range(0, 3) != 0);
            endcase
            if (dv[d] && rdy[d]) begin
                n_words[d]++;
                last_data[d] = ddat[d];
                last_pe[d]   = dpe[d];
                last_fe[d]   = dfe[d];
            end
        end
        if (rst) pend.delete();
    end

    initial begin
        rst = 1'b1;
        rx  = 3'b111;
        rdy = 3'b111;
        for (int d = 0; d < 3; d++) begin
            ready_mode[d] = 1;
            m_full[d]     = 1'b0;
            m_data[d]     = '0;
            m_pe[d]       = 1'b0;
            m_fe[d]       = 1'b0;
            n_words[d]    = 0;
            n_ovr[d]      = 0;
            rise_cyc[d]   = 0;
            last_start[d] = 0;
            last_data[d]  = '0;
            last_pe[d]    = 1'b0;
            last_fe[d]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset data", 32'(ddat[0]), 32'h0);
        check("reset flags", 32'({dv[0], dpe[0], dfe[0], dovr[0], dbusy[0]}), 32'h0);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post-reset busy", 32'(dbusy), 32'h0);

        // 8N1 word, with its exact arrival edge
        w0 = n_words[0];
        send_frame(0, 9'h055, 1'b0, 2'b11, 2);
        check("t1 words", 32'(n_words[0] - w0), 32'd1);
        check("t1 data", 32'(last_data[0]), 32'h55);
        check("t1 errs", 32'({last_pe[0], last_fe[0]}), 32'h0);
        check("t1 latency", 32'(rise_cyc[0] - last_start[0]), 32'd79);
        check("t1 busy", 32'(dbusy[0]), 32'h0);

        // Even parity: 0xA3 has even weight, so a parity bit of 1 is wrong
        send_frame(1, 9'h0A3, 1'b1, 2'b11, 2);
        check("t2 data", 32'(last_data[1]), 32'hA3);
        check("t2 bad parity", 32'(last_pe[1]), 32'h1);
        send_frame(1, 9'h0A3, 1'b0, 2'b11, 2);
        check("t2 good parity", 32'(last_pe[1]), 32'h0);

        // Short low glitch is rejected
        w0 = n_words[0];
        @(negedge clk);
        rx[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("t3 busy in glitch", 32'(dbusy[0]), 32'h1);
        rx[0] = 1'b1;
        repeat (24) @(negedge clk);
        check("t3 busy after", 32'(dbusy[0]), 32'h0);
        check("t3 words", 32'(n_words[0] - w0), 32'd0);

        // Low stop bit, then a clean frame
        send_frame(0, 9'h03C, 1'b0, 2'b00, 2);
        check("t4 data", 32'(last_data[0]), 32'h3C);
        check("t4 frame_err", 32'(last_fe[0]), 32'h1);
        send_frame(0, 9'h081, 1'b0, 2'b11, 2);
        check("t4 next data", 32'(last_data[0]), 32'h81);
        check("t4 next frame_err", 32'(last_fe[0]), 32'h0);

        // Stalled output: second word dropped with an overrun pulse
        ready_mode[0] = 0;
        w0 = n_words[0];
        o0 = n_ovr[0];
        @(negedge clk);
        send_frame(0, 9'h011, 1'b0, 2'b11, 0);
        send_frame(0, 9'h022, 1'b0, 2'b11, 2);
        check("t5 overruns", 32'(n_ovr[0] - o0), 32'd1);
        check("t5 held valid", 32'(dv[0]), 32'h1);
        check("t5 held data", 32'(ddat[0]), 32'h11);
        ready_mode[0] = 1;
        repeat (3) @(negedge clk);
        check("t5 words", 32'(n_words[0] - w0), 32'd1);
        check("t5 taken data", 32'(last_data[0]), 32'h11);
        check("t5 valid drop", 32'(dv[0]), 32'h0);

        // Line held low for 40 bit times: exactly one zero word flagged as framing error
        w0 = n_words[0];
        @(negedge clk);
        be.dut  = 0;
        be.done = done_edge(0, cyc);
        be.data = '0;
        be.perr = 1'b0;
        be.ferr = 1'b1;
        pend.push_back(be);
        rx[0] = 1'b0;
        repeat (40 * C0) @(negedge clk);
        rx[0] = 1'b1;
        repeat (2 * C0) @(negedge clk);
        check("t6 break words", 32'(n_words[0] - w0), 32'd1);
        check("t6 break data", 32'(last_data[0]), 32'h0);
        check("t6 break frame_err", 32'(last_fe[0]), 32'h1);
        send_frame(0, 9'h07E, 1'b0, 2'b11, 2);
        check("t6 after data", 32'(last_data[0]), 32'h7E);
        check("t6 after frame_err", 32'(last_fe[0]), 32'h0);

        // Random frames on all configurations with random backpressure
        for (int d = 0; d < 3; d++) ready_mode[d] = 2;
        fork
            random_frames(0, 12);
            random_frames(1, 12);
            random_frames(2, 12);
        join
        for (int d = 0; d < 3; d++) ready_mode[d] = 1;
        repeat (8) @(negedge clk);

        // Reset in the middle of a frame
        w0 = n_words[0];
        @(negedge clk);
        rx[0] = 1'b0;
        repeat (3 * C0) @(negedge clk);
        check("t7 busy mid-frame", 32'(dbusy[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t7 reset data", 32'(ddat[0]), 32'h0);
        check("t7 reset flags", 32'({dv[0], dpe[0], dfe[0], dovr[0], dbusy[0]}), 32'h0);
        rx[0] = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (30 * C0) @(negedge clk);
        check("t7 words", 32'(n_words[0] - w0), 32'd0);
        check("t7 busy", 32'(dbusy[0]), 32'h0);

        check("pending drained", 32'(pend.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
Parametrised next-generation UART receiver that converts the serial line into a byte stream rather than a fixed-length buffer. It uses mid-bit sampling with false-start rejection, and supports configurable data width, parity and stop bits. Each received word is delivered on a valid/ready interface together with per-word parity and framing error flags and an overrun indication. It sits between the board RX pin and downstream FIFOs or command parsers.

Parameters:
P_CLKS_PER_BIT, 8, clk cycles per UART bit; legal range >= 4.
P_DATA_BITS, 8, data bits per frame; legal 5..9, sent LSB first.
P_PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
P_STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
i_rx  input  1  asynchronous UART RX line; idles high
o_data  output  P_DATA_BITS  received word
o_valid  output  1  o_data and error flags valid
i_ready  input  1  downstream accepts the word; transfer occurs when o_valid && i_ready
o_parity_err  output  1  parity mismatch on the presented word (qualified by o_valid)
o_frame_err  output  1  a stop bit was sampled low on the presented word (qualified by o_valid)
o_overrun  output  1  one-cycle pulse: a completed frame was dropped
o_busy  output  1  high while the FSM is outside IDLE

Behaviour:
- Reset (async assert; all regs clear immediately):
  - Synchroniser flops = 1, FSM = IDLE.
  - o_data = 0; o_valid, o_parity_err, o_frame_err, o_overrun, o_busy = 0.
- Synchroniser: i_rx passes through 2 flops; rx_s is the second flop. All decisions use rx_s only.
- Bit timer: counter of width $clog2(P_CLKS_PER_BIT). A "sample" strobe fires when the counter reaches its terminal count, then the counter reloads.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: rx_s == 0 -> START; timer loaded so the first sample falls P_CLKS_PER_BIT/2 (integer division) cycles later.
  - START, on sample:
    - rx_s == 1 -> false start, back to IDLE, nothing emitted.
    - rx_s == 0 -> DATA; timer period becomes P_CLKS_PER_BIT.
  - DATA: each sample shifts rx_s into the shift register, LSB first. After P_DATA_BITS samples -> PARITY if P_PARITY != 0, else STOP.
  - PARITY: on sample, compare rx_s with the expected parity. Odd mode: XOR of data bits plus parity bit must equal 1; even mode: it must equal 0. Mismatch latches the parity error. -> STOP.
  - STOP: P_STOP_BITS samples; any sample of 0 latches the frame error. On the last stop sample the frame completes. Next state:
    - BREAK if the frame error is set and all data bits are 0;
    - otherwise IDLE. A start edge is accepted on the very next cycle.
  - BREAK: remain until rx_s == 1, then IDLE. Exactly one word (with o_frame_err = 1) is emitted per break.
- Output register, updated on the frame-complete cycle C; results are visible from cycle C+1:
  - o_valid == 0, or o_valid && i_ready in cycle C: load o_data and both error flags, set o_valid = 1.
  - o_valid && !i_ready in cycle C: the new frame is discarded, o_overrun pulses high for exactly one cycle, and the held word and flags are unchanged.
- o_valid, o_data and the error flags stay stable until a transfer occurs. A transfer with no new frame in the same cycle clears o_valid on the next cycle.
- Latency: o_valid rises 1 cycle after the mid-sample of the last stop bit. That point is about 2 sync cycles plus (frame_bits - 0.5) * P_CLKS_PER_BIT cycles after the i_rx falling edge.
- A stuck-low line produces no further words after the break word.
- Reset asserted mid-frame discards the partial frame and returns to IDLE. A line still low after reset release is treated as a new start edge.

Test Plan:
1. Defaults (8N1, 8 clk/bit), send 0x55 with i_ready = 1 -> one o_valid pulse, o_data = 0x55, both errors 0, o_busy low afterwards.
2. P_PARITY = 2, send 0xA3 with the parity bit = 1 (wrong; correct is 0) -> o_data = 0xA3, o_parity_err = 1; resend with parity 0 -> o_parity_err = 0.
3. Low glitch on i_rx of 3 cycles (shorter than 4) while idle -> FSM returns to IDLE, o_valid never asserts.
4. Send 0x3C with the stop bit driven 0, followed by an idle line -> o_data = 0x3C, o_frame_err = 1; a following 0x81 frame is received cleanly.
5. i_ready = 0, send 0x11 then 0x22 back to back -> o_data holds 0x11, o_overrun pulses once at the end of 0x22; raise i_ready -> 0x11 transferred, o_valid drops.
6. Hold i_rx low for 40 bit times, then high, then send 0x7E -> exactly one word 0x00 with o_frame_err = 1, then 0x7E clean. Repeat with rst asserted mid-frame -> all outputs 0 immediately, no word emitted.
